dm_arbiter: RTL
===============

Name: dm_arbiter

Overview:
- Shares the single-port data memory between two requesters: the CPU load/store path (port 0) and the debug/loader port (port 1).
- Uses a valid/ready request handshake with one outstanding read at a time.
- Arbitrates round-robin on conflict.
- Tracks the read-data latency of the synchronous memory, whose q is registered one cycle after rden.
- Sits between the CPU core and the DM instance. The CPU uses p0_ready low as its stall condition.

Parameters:
- ADDR_W, 12, memory address bits; requester addresses are truncated to [ADDR_W-1:0].
- DATA_W, 32, data word width.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  input  1  system clock; all state updates on posedge clk
- rst  input  1  asynchronous active-low reset
- p0_valid  input  1  CPU request valid
- p0_we  input  1  CPU request is a write (1) or read (0)
- p0_addr  input  32  CPU word address
- p0_wdata  input  DATA_W  CPU write data
- p0_ready  output  1  CPU request accepted this cycle
- p0_rvalid  output  1  CPU read data valid (1-cycle pulse)
- p0_rdata  output  DATA_W  CPU read data
- p1_valid, p1_we, p1_addr, p1_wdata, p1_ready, p1_rvalid, p1_rdata  as for p0, debug port
- mem_addr  output  ADDR_W  memory address
- mem_data  output  DATA_W  memory write data
- mem_rden  output  1  memory read enable
- mem_wren  output  1  memory write enable
- mem_q  input  DATA_W  memory read data, valid the cycle after mem_rden
- p0_stall_cnt  output  CNT_W  cycles with p0_valid=1 and p0_ready=0, saturating

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, last_grant=1 (so port 0 wins the first conflict), rd_owner=0, p0/p1_rvalid=0, p0/p1_rdata=0, p0_stall_cnt=0.
- While rst=0, all combinational outputs (ready, mem_rden, mem_wren, mem_addr, mem_data) are forced to 0.
- States:
  - IDLE: may grant.
  - RD_WAIT: read issued last cycle; no grant this cycle.
- Grant (combinational, IDLE only):
  - One port valid: that port is granted.
  - Both valid: the port != last_grant is granted.
  - Neither valid: no grant; all mem_* outputs are 0.
- Granted port sees pX_ready=1 in the same cycle. The mem_* signals are driven from its request (addr truncated, wdata, we → mem_wren, !we → mem_rden). The non-granted port's ready is 0.
- Ready may depend combinationally on valid. Requesters hold valid, we, addr and wdata stable until ready; dropping valid before ready is legal and cancels the request.
- On the grant edge: last_grant ← granted port.
  - Read: state ← RD_WAIT, rd_owner ← granted port.
  - Write: state stays IDLE. A write completes in 1 cycle, so back-to-back writes are allowed every cycle.
- RD_WAIT: both readys are 0. On the next edge:
  - p[rd_owner]_rdata ← mem_q and p[rd_owner]_rvalid ← 1 for exactly one cycle.
  - The other port's rdata holds its last value.
  - state ← IDLE.
- Read latency: request accepted in cycle N, rvalid/rdata in cycle N+2. Read throughput is 1 per 2 cycles.
- Stall counter: increments when p0_valid & !p0_ready, holds at all-ones (saturates, no wrap), clears only on reset.
- Reset mid-read: the pending response is discarded; no rvalid follows reset release.
- Addresses above 2^ADDR_W-1 alias by truncation; no error is flagged.

Decomposition:
- Shared package/header: state encodings (IDLE=1'b0, RD_WAIT=1'b1) and port index constants (PORT_CPU=0, PORT_DBG=1).
- One sub-module is natural: rr_arb2, a 2-requester round-robin grant with a last_grant register and an enable input. The FSM, response steering and counter stay in dm_arbiter.

Test Plan:
- Reset release, p0 write addr=5 data=32'hDEAD → p0_ready=1 same cycle; mem_wren=1, mem_addr=5; next cycle state=IDLE.
- p0 read addr=5 after that write (memory model returns 32'hDEAD) → mem_rden in cycle N, p0_rvalid=1 with p0_rdata=32'hDEAD in N+2; p1_rvalid stays 0.
- Both ports valid reads every cycle, first conflict after reset → grants alternate p0,p1,p0,p1, one grant per 2 cycles; p0_stall_cnt increments during waits.
- Both ports valid writes continuously → grants alternate every cycle, p0_ready=1 on alternate cycles, mem_wren=1 every cycle.
- Assert rst=0 in the cycle after a p1 read grant → p1_rvalid never pulses, state=IDLE, counters=0; next p0 read completes normally.
- Hold p0_valid with p1 monopolizing (force p1 every cycle, p0 at 65,540 stall cycles with CNT_W=16) → p0_stall_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states and requester
// port indices.
package dm_arbiter_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int unsigned REQ_ADDR_W = 32;

    // Index of the port that is not `p`.
    function automatic logic other_port(input logic p);
        return ~p;
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Bundle of the two requester handshakes and the single-port memory bus.
// The arbiter uses the slave view; requesters and memory use the master view.
interface dm_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              p0_valid;
    logic              p0_we;
    logic [31:0]       p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ready;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_valid;
    logic              p1_we;
    logic [31:0]       p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ready;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_rden;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  p0_valid, p0_we, p0_addr, p0_wdata,
        input  p1_valid, p1_we, p1_addr, p1_wdata,
        input  mem_q,
        output p0_ready, p0_rvalid, p0_rdata,
        output p1_ready, p1_rvalid, p1_rdata,
        output mem_addr, mem_data, mem_rden, mem_wren
    );

    modport master (
        output p0_valid, p0_we, p0_addr, p0_wdata,
        output p1_valid, p1_we, p1_addr, p1_wdata,
        output mem_q,
        input  p0_ready, p0_rvalid, p0_rdata,
        input  p1_ready, p1_rvalid, p1_rdata,
        input  mem_addr, mem_data, mem_rden, mem_wren
    );

endinterface

// File: rtl/dm_arbiter_rr_arb2.sv
// Two-requester round-robin grant. On a conflict the port that did not win
// last time is chosen; the winner is remembered whenever a grant is issued.
module dm_arbiter_rr_arb2
    import dm_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output logic       gnt_idx_o
);

    logic last_q;
    logic last_d;

    // Grant selection and next last-grant value
    always_comb begin
        gnt_o     = 2'b00;
        gnt_idx_o = PORT_CPU;
        if (en_i) begin
            case (req_i)
                2'b01: begin
                    gnt_o     = 2'b01;
                    gnt_idx_o = PORT_CPU;
                end
                2'b10: begin
                    gnt_o     = 2'b10;
                    gnt_idx_o = PORT_DBG;
                end
                2'b11: begin
                    gnt_idx_o = other_port(last_q);
                    gnt_o     = (gnt_idx_o == PORT_DBG) ? 2'b10 : 2'b01;
                end
                default: begin
                    gnt_o     = 2'b00;
                    gnt_idx_o = PORT_CPU;
                end
            endcase
        end else begin
            gnt_o     = 2'b00;
            gnt_idx_o = PORT_CPU;
        end
        last_d = (gnt_o != 2'b00) ? gnt_idx_o : last_q;
    end

    // Last-grant register; resets to DBG so CPU wins the first conflict
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= PORT_DBG;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: shares a single-port synchronous RAM between the CPU
// (port 0) and the debug/loader (port 1), one outstanding read at a time.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    dm_arbiter_if.slave      bus,
    output logic [CNT_W-1:0] p0_stall_cnt
);

    state_e            state_q;
    state_e            state_d;
    logic              rd_owner_q;
    logic              rd_owner_d;
    logic              p0_rvalid_q;
    logic              p1_rvalid_q;
    logic [DATA_W-1:0] p0_rdata_q;
    logic [DATA_W-1:0] p1_rdata_q;
    logic [CNT_W-1:0]  stall_q;

    logic [1:0]        gnt_s;
    logic              gnt_idx_s;
    logic              arb_en_s;
    logic              sel_we_s;
    logic              resp_p0_s;
    logic              resp_p1_s;
    logic              stall_inc_s;
    logic              unused_s;

    // Upper requester address bits alias away by truncation.
    assign unused_s = ^{bus.p0_addr[REQ_ADDR_W-1:ADDR_W], bus.p1_addr[REQ_ADDR_W-1:ADDR_W]};

    assign arb_en_s = rst & (state_q == ST_IDLE);

    dm_arbiter_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .en_i      (arb_en_s),
        .req_i     ({bus.p1_valid, bus.p0_valid}),
        .gnt_o     (gnt_s),
        .gnt_idx_o (gnt_idx_s)
    );

    // FSM next state plus memory-bus steering from the granted request
    always_comb begin
        state_d      = state_q;
        rd_owner_d   = rd_owner_q;
        sel_we_s     = 1'b0;
        bus.p0_ready = 1'b0;
        bus.p1_ready = 1'b0;
        bus.mem_addr = {ADDR_W{1'b0}};
        bus.mem_data = {DATA_W{1'b0}};
        bus.mem_rden = 1'b0;
        bus.mem_wren = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_s != 2'b00) begin
                    bus.p0_ready = gnt_s[0];
                    bus.p1_ready = gnt_s[1];
                    if (gnt_idx_s == PORT_DBG) begin
                        sel_we_s     = bus.p1_we;
                        bus.mem_addr = bus.p1_addr[ADDR_W-1:0];
                        bus.mem_data = bus.p1_wdata;
                    end else begin
                        sel_we_s     = bus.p0_we;
                        bus.mem_addr = bus.p0_addr[ADDR_W-1:0];
                        bus.mem_data = bus.p0_wdata;
                    end
                    bus.mem_wren = sel_we_s;
                    bus.mem_rden = ~sel_we_s;
                    if (sel_we_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_RD_WAIT;
                        rd_owner_d = gnt_idx_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Response steering and stall detection
    always_comb begin
        resp_p0_s   = (state_q == ST_RD_WAIT) && (rd_owner_q == PORT_CPU);
        resp_p1_s   = (state_q == ST_RD_WAIT) && (rd_owner_q == PORT_DBG);
        stall_inc_s = bus.p0_valid && !gnt_s[0] && (stall_q != {CNT_W{1'b1}});
    end

    // FSM state and read-owner registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            rd_owner_q <= PORT_CPU;
        end else begin
            state_q    <= state_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Read-data capture; the non-owner port keeps its previous data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= {DATA_W{1'b0}};
            p1_rdata_q  <= {DATA_W{1'b0}};
        end else begin
            p0_rvalid_q <= resp_p0_s;
            p1_rvalid_q <= resp_p1_s;
            if (resp_p0_s) begin
                p0_rdata_q <= bus.mem_q;
            end
            if (resp_p1_s) begin
                p1_rdata_q <= bus.mem_q;
            end
        end
    end

    // Saturating CPU stall counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= {CNT_W{1'b0}};
        end else if (stall_inc_s) begin
            stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.p0_rvalid = p0_rvalid_q;
    assign bus.p1_rvalid = p1_rvalid_q;
    assign bus.p0_rdata  = p0_rdata_q;
    assign bus.p1_rdata  = p1_rdata_q;
    assign p0_stall_cnt  = stall_q;

endmodule
